// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// One bit of the result is produced per SHIFT cycle; non-decimal digits abort early with err set.
module bcd_to_binary_seq #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (bcd[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Shift right one bit, then pull every BCD digit that reached 8 or more back by 3.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = {1'b0, w[WORK_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            s[BIN_W + 4*i +: 4] = (s[BIN_W + 4*i +: 4] >= 4'd8) ?
                                  (s[BIN_W + 4*i +: 4] - 4'd3) :
                                  s[BIN_W + 4*i +: 4];
        end
        return s;
    endfunction

    state_t              state_r, state_s;
    logic [WORK_W-1:0]   work_r, work_s, step_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [BIN_W-1:0]    bin_r, bin_s;
    logic                err_r, err_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    assign step_s     = dabble_step(work_r);
    assign busy       = busy_r;
    assign done       = done_r;
    assign binary_out = bin_r;
    assign err        = err_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        cnt_s   = cnt_r;
        bin_s   = bin_r;
        err_s   = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    work_s  = {bcd_in, {BIN_W{1'b0}}};
                    state_s = S_CHECK;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (has_bad_digit(work_r[WORK_W-1:BIN_W])) begin
                    err_s   = 1'b1;
                    bin_s   = {BIN_W{1'b0}};
                    state_s = S_DONE;
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_s = step_s;
                cnt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_CNT) begin
                    bin_s   = step_s[BIN_W-1:0];
                    err_s   = 1'b0;
                    state_s = S_DONE;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_r <= {WORK_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            bin_r  <= {BIN_W{1'b0}};
            err_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            work_r <= work_s;
            cnt_r  <= cnt_s;
            bin_r  <= bin_s;
            err_r  <= err_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: directed cases from the test plan plus random BCD words,
// checked against a decimal-arithmetic reference model including done-pulse timing.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bcd_in;
    logic        busy;
    logic        done;
    logic [26:0] binary_out;
    logic        err;

    bcd_to_binary_seq #(.DIGITS(8), .BIN_W(27)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .binary_out(binary_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] val;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: sum of digit * 10^i; any digit above 9 gives err=1 and value 0.
    function automatic void ref_model(input logic [31:0] b, output logic [26:0] v, output logic e);
        longint acc = 0;
        longint pw = 1;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int d;
            d = int'(b[4*i +: 4]);
            if (d > 9) e = 1'b1;
            acc += d * pw;
            pw *= 10;
        end
        v = e ? 27'd0 : acc[26:0];
    endfunction

    // Monitor: every done pulse must match the oldest expected result, at the expected cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("binary_out", {5'd0, binary_out}, {5'd0, e.val});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("done_cycle", cyc, e.due);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Drive a one-cycle start at a negedge while idle; accept edge is the next posedge.
    task automatic issue(input logic [31:0] b);
        exp_t e;
        ref_model(b, e.val, e.err);
        e.due = cyc + 1 + (e.err ? 1 : 28);
        sb_q.push_back(e);
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = $urandom;
    endtask

    initial begin
        int          busy_cnt;
        int unsigned k;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; bcd_in = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bin", {5'd0, binary_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 12345678, with busy-length check.
        issue(32'h12345678);
        busy_cnt = 0;
        while (busy && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", busy_cnt, 32'd29);
        chk("done_after", {31'd0, done}, 32'd0);

        wait_idle(); issue(32'h99999999);
        wait_idle(); issue(32'h00000000);
        wait_idle(); issue(32'h00000001);
        wait_idle(); issue(32'h1234A678);
        wait_idle(); issue(32'h00000042);

        // Start pulse during a conversion must be ignored.
        wait_idle(); issue(32'h00000250);
        repeat (9) @(negedge clk);
        bcd_in = 32'h00000999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("ignored_start_q", sb_q.size(), 32'd0);

        // Asynchronous reset mid-conversion.
        issue(32'h00004321);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_bin", {5'd0, binary_out}, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        sb_q.delete();
        rst = 1'b0;
        @(negedge clk);
        issue(32'h00001000);

        // start held high: back-to-back conversions 30 cycles apart.
        wait_idle();
        begin
            exp_t e;
            k = cyc;
            e.val = 27'd7; e.err = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e.due = k + 29 + 30 * i;
                sb_q.push_back(e);
            end
            bcd_in = 32'h00000007;
            start  = 1'b1;
            repeat (61) @(negedge clk);
            start  = 1'b0;
        end

        // Random words, roughly one in five with a non-decimal digit.
        for (int n = 0; n < 24; n++) begin
            rb = 32'd0;
            for (int i = 0; i < 8; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) rb[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_idle();
            issue(rb);
        end

        wait_idle();
        @(negedge clk);
        chk("drain_q", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
